// File: rtl/axi_lite_pkg.sv
// +------------------------------------------------------------------------+
// | axi_lite_pkg: AXI4-Lite response codes, master FSM states and a         |
// | DATA_WIDTH legality helper shared by the AXI4-Lite master.              |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } mst_state_e;

  // AXI4-Lite only permits 32- or 64-bit data buses.
  function automatic bit data_width_ok(input int unsigned width);
    return (width == 32) || (width == 64);
  endfunction

endpackage : axi_lite_pkg

`default_nettype wire

// File: rtl/axi4_lite_master_if.sv
// +------------------------------------------------------------------------+
// | axi4_lite_master_if: AXI4-Lite bus bundle with master/slave modports.  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

interface axi4_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [2:0]            axi_awprot;

  logic [DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_WIDTH-1:0] axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;

  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;

  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [2:0]            axi_arprot;

  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, axi_awprot,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arvalid, axi_arprot,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_awprot,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arvalid, axi_arprot,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );

endinterface : axi4_lite_master_if

`default_nettype wire

// File: rtl/axi4_lite_master.sv
// +------------------------------------------------------------------------+
// | axi4_lite_master: turns a valid/ready command stream into single       |
// | AXI4-Lite read/write transactions with a registered response + latency.|
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module axi4_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  parameter int unsigned LAT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [LAT_WIDTH-1:0]    rsp_latency,

  axi4_lite_master_if.master      axi
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
    $error("axi4_lite_master: DATA_WIDTH must be 32 or 64");
  end

  mst_state_e             state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  wstrb_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   bready_q;
  logic                   arvalid_q;
  logic                   rready_q;
  logic                   rsp_valid_q;
  logic                   rsp_write_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic [1:0]             rsp_resp_q;
  logic [LAT_WIDTH-1:0]   rsp_lat_q;
  logic [LAT_WIDTH-1:0]   lat_q;

  logic [LAT_WIDTH-1:0]   lat_d;
  logic                   aw_done_d;
  logic                   w_done_d;

  // Saturating increment: the frozen value includes the handshake cycle itself.
  assign lat_d     = (&lat_q) ? lat_q : lat_q + {{(LAT_WIDTH-1){1'b0}}, 1'b1};
  assign aw_done_d = !awvalid_q || axi.axi_awready;
  assign w_done_d  = !wvalid_q  || axi.axi_wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      rsp_lat_q   <= '0;
      lat_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            lat_q  <= '0;
            if (cmd_write) begin
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end

        // AW and W retire independently; move on once both have handshaken.
        ST_WR_REQ: begin
          lat_q <= lat_d;
          if (awvalid_q && axi.axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi.axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          lat_q <= lat_d;
          if (axi.axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= axi.axi_bresp;
            rsp_lat_q   <= lat_d;
            state_q     <= ST_RSP;
          end
        end

        ST_RD_REQ: begin
          lat_q <= lat_d;
          if (axi.axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end

        ST_RD_RESP: begin
          lat_q <= lat_d;
          if (axi.axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= axi.axi_rdata;
            rsp_resp_q  <= axi.axi_rresp;
            rsp_lat_q   <= lat_d;
            state_q     <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state_q == ST_IDLE);

  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign rsp_latency     = rsp_lat_q;

  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_awprot  = PROT;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = wstrb_q;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_bready  = bready_q;
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_arprot  = PROT;
  assign axi.axi_rready  = rready_q;

endmodule : axi4_lite_master

`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
// +------------------------------------------------------------------------+
// | tb_axi4_lite_master: directed scoreboard bench with a wait-configurable|
// | AXI4-Lite slave model for axi4_lite_master.                             |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_axi4_lite_master;

  localparam logic [2:0] TB_PROT = 3'b010;

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  axi4_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(TB_PROT), .LAT_WIDTH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .axi(axi)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_lat = 1;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  int          b_hs = 0;
  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [31:0] mem [0:16383];

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign axi.axi_awready = (aw_cnt >= aw_wait);
  assign axi.axi_wready  = (w_cnt >= w_wait);
  assign axi.axi_arready = (ar_cnt >= ar_wait);
  assign axi.axi_bvalid  = s_bvalid;
  assign axi.axi_bresp   = s_bresp;
  assign axi.axi_rvalid  = s_rvalid;
  assign axi.axi_rresp   = s_rresp;
  assign axi.axi_rdata   = s_rdata;

  assign aw_hs   = axi.axi_awvalid && axi.axi_awready;
  assign w_hs    = axi.axi_wvalid && axi.axi_wready;
  assign ar_hs   = axi.axi_arvalid && axi.axi_arready;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_addr = aw_hs ? axi.axi_awaddr : aw_a;
  assign wr_data = w_hs ? axi.axi_wdata : w_d;
  assign wr_strb = w_hs ? axi.axi_wstrb : w_s;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a[31] ? 32'h0 : mem[a[15:2]];
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rresp <= 2'b00; s_rdata <= 32'h0;
      aw_a <= 32'h0; w_d <= 32'h0; w_s <= 4'h0; ar_a <= 32'h0;
    end else begin
      aw_cnt <= aw_hs ? 0 : (axi.axi_awvalid ? aw_cnt + 1 : aw_cnt);
      w_cnt  <= w_hs  ? 0 : (axi.axi_wvalid  ? w_cnt + 1  : w_cnt);
      ar_cnt <= ar_hs ? 0 : (axi.axi_arvalid ? ar_cnt + 1 : ar_cnt);
      if (aw_hs) aw_a <= axi.axi_awaddr;
      if (w_hs) begin w_d <= axi.axi_wdata; w_s <= axi.axi_wstrb; end
      if (s_bvalid && axi.axi_bready) begin
        s_bvalid <= 1'b0;
        b_hs     <= b_hs + 1;
      end
      if (wr_fire) begin
        if (!wr_addr[31]) mem[wr_addr[15:2]] <= merge(mem[wr_addr[15:2]], wr_data, wr_strb);
        s_bvalid <= 1'b1;
        s_bresp  <= wr_addr[31] ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        aw_got <= aw_got || aw_hs;
        w_got  <= w_got || w_hs;
      end
      if (s_rvalid && axi.axi_rready) s_rvalid <= 1'b0;
      if (ar_hs) begin
        if (r_lat <= 1) begin
          s_rvalid <= 1'b1;
          s_rdata  <= rd_val(axi.axi_araddr);
          s_rresp  <= axi.axi_araddr[31] ? 2'b10 : 2'b00;
        end else begin
          r_pend <= 1'b1;
          r_cnt  <= r_lat - 1;
          ar_a   <= axi.axi_araddr;
        end
      end else if (r_pend) begin
        if (r_cnt == 1) begin
          s_rvalid <= 1'b1;
          s_rdata  <= rd_val(ar_a);
          s_rresp  <= ar_a[31] ? 2'b10 : 2'b00;
          r_pend   <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] erd, input logic [1:0] ers,
                      input int elat, input bit push, output int t_acc);
    exp_t e;
    int   k;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge aclk); k++; end
    chk("cmd_accept", cmd_ready, 1);
    if (push) begin
      e.w = w; e.rdata = erd; e.resp = ers; e.lat = elat;
      sb.push_back(e);
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic recv(input string tag, input int hold, input bit poke,
                      input int exp_dly, input int t_acc);
    exp_t e;
    int   k;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 200) begin @(negedge aclk); k++; end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
    if (rsp_valid !== 1'b1) return;
    if (exp_dly >= 0) chk({tag, "_rsp_cycle"}, cyc - t_acc, exp_dly);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000;
      end
      @(negedge aclk);
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_hold_lat"}, rsp_latency, e.lat);
      chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_hold_no_ar"}, axi.axi_arvalid, 0);
    end
    cmd_valid = 1'b0;
    chk({tag, "_write"}, rsp_write, e.w);
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_resp"}, rsp_resp, e.resp);
    chk({tag, "_latency"}, rsp_latency, e.lat);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_dropped"}, rsp_valid, 0);
    chk({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_idle_no_valid"}, axi.axi_arvalid | axi.axi_awvalid | axi.axi_wvalid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_valids"}, {axi.axi_awvalid, axi.axi_wvalid, axi.axi_arvalid,
                           axi.axi_bready, axi.axi_rready, rsp_valid}, 6'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int bh;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;

    #12;
    chk_reset_vals("reset");
    chk("reset_awaddr", axi.axi_awaddr, 32'h0);
    chk("reset_wdata", axi.axi_wdata, 32'h0);
    chk("reset_wstrb", axi.axi_wstrb, 4'h0);
    chk("reset_rsp_fields", {rsp_write, rsp_rdata, rsp_resp, rsp_latency}, 51'h0);
    chk("reset_prot", {axi.axi_awprot, axi.axi_arprot}, {TB_PROT, TB_PROT});
    @(negedge aclk);
    aresetn = 1'b1;

    // Zero-wait write then read-back
    send(1'b1, 32'h1000, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 2, 1'b1, t);
    chk("wr_aw_w_valid", {axi.axi_awvalid, axi.axi_wvalid}, 2'b11);
    chk("wr_awaddr", axi.axi_awaddr, 32'h1000);
    chk("wr_wdata", axi.axi_wdata, 32'h1234_5678);
    chk("wr_wstrb", axi.axi_wstrb, 4'hF);
    chk("wr_cmd_ready_low", cmd_ready, 0);
    recv("wr1", 0, 1'b0, 2, t);
    send(1'b0, 32'h1000, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 2, 1'b1, t);
    chk("rd_arvalid", axi.axi_arvalid, 1);
    chk("rd_araddr", axi.axi_araddr, 32'h1000);
    recv("rd1", 0, 1'b0, 2, t);

    // W accepted three cycles ahead of AW
    aw_wait = 3;
    bh = b_hs;
    send(1'b1, 32'h3000, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, 5, 1'b1, t);
    for (int k = 1; k <= 4; k++) begin
      chk("split_awvalid_held", axi.axi_awvalid, 1);
      chk("split_awaddr_stable", axi.axi_awaddr, 32'h3000);
      chk("split_wvalid", axi.axi_wvalid, (k == 1) ? 1 : 0);
      @(negedge aclk);
    end
    chk("split_awvalid_dropped", axi.axi_awvalid, 0);
    recv("split", 0, 1'b0, -1, t);
    chk("split_single_b", b_hs - bh, 1);
    aw_wait = 0;

    // Partial strobes over an all-ones word
    send(1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00, 2, 1'b1, t);
    recv("fill", 0, 1'b0, 2, t);
    send(1'b1, 32'h2000, 32'hAABB_CCDD, 4'b0101, 32'h0, 2'b00, 2, 1'b1, t);
    recv("strb", 0, 1'b0, 2, t);

    // Response backpressure with a competing command presented
    send(1'b0, 32'h2000, 32'h0, 4'h0, 32'hFFBB_FFDD, 2'b00, 2, 1'b1, t);
    recv("hold", 5, 1'b1, 2, t);

    // Slow SLVERR read, then a normal read
    r_lat = 4;
    send(1'b0, 32'h9000_0000, 32'h0, 4'h0, 32'h0, 2'b10, 5, 1'b1, t);
    recv("slverr", 0, 1'b0, -1, t);
    r_lat = 1;
    send(1'b0, 32'h3000, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 2, 1'b1, t);
    recv("after_err", 0, 1'b0, 2, t);

    // Reset while arvalid is pending
    ar_wait = 10;
    send(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 2'b00, 0, 1'b0, t);
    chk("pend_arvalid", axi.axi_arvalid, 1);
    @(negedge aclk);
    chk("pend_arvalid_held", axi.axi_arvalid, 1);
    #2 aresetn = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    ar_wait = 0;
    @(negedge aclk);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    send(1'b0, 32'h1000, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 2, 1'b1, t);
    recv("post_reset", 0, 1'b0, 2, t);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_axi4_lite_master

`default_nettype wire

// File: doc/axi4_lite_master.md
# axi4_lite_master

Synthesizable, parametrised AXI4-Lite master engine that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions, one outstanding at a time. It replaces task-driven bus stimulus with real RTL, so CPU-side logic or a bench sequencer can drive `axi4_lite_slave` and other AXI4-Lite peripherals. New over task-based stimulus: generic address/data width, byte strobes from the command, concurrent AW/W issue with independent drop, a response channel with backpressure, and per-transaction latency measurement.

## Interface
- `ADDR_WIDTH`, 32, AXI and command address width.
- `DATA_WIDTH`, 32, data width; must be 32 or 64; strobe width is `DATA_WIDTH/8`.
- `PROT`, 3'b000, constant driven on `axi_awprot`/`axi_arprot`.
- `LAT_WIDTH`, 16, width of the latency counter.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  transaction address.
- `cmd_wdata`  in  DATA_WIDTH  write data (ignored for reads).
- `cmd_wstrb`  in  DATA_WIDTH/8  write strobes (ignored for reads).
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_write`  out  1  echo of `cmd_write`.
- `rsp_rdata`  out  DATA_WIDTH  read data (0 for writes).
- `rsp_resp`  out  2  BRESP/RRESP from slave.
- `rsp_latency`  out  LAT_WIDTH  cycles from command accept to final AXI handshake, saturating.
- `axi_aw{addr,valid,ready,prot}`, `axi_w{data,strb,valid,ready}`, `axi_b{resp,valid,ready}`, `axi_ar{addr,valid,ready,prot}`, `axi_r{data,resp,valid,ready}`: standard AXI4-Lite master-side directions and widths.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid&cmd_ready`, register the command and go to WR_REQ if `cmd_write`, otherwise RD_REQ.
- WR_REQ: `axi_awvalid` and `axi_wvalid` are asserted together. Each deasserts in the cycle after its own handshake, and address/data stay stable until then. Once both handshakes are done (same or different cycles), go to WR_RESP.
- WR_RESP: `axi_bready`=1. On `bvalid`, capture `bresp` and go to RSP.
- RD_REQ: `axi_arvalid`=1 until the handshake, then RD_RESP.
- RD_RESP: `axi_rready`=1. On `rvalid`, capture `rdata`/`rresp` and go to RSP.
- RSP: `rsp_valid`=1 and all response fields are held stable. On `rsp_ready`, go to IDLE.
- Latency counter: cleared on command accept, then increments every cycle in WR_*/RD_* states and saturates at all-ones. Its value is frozen into `rsp_latency` on the final B/R handshake.
- A valid is never dropped before its handshake. `bready`/`rready` are asserted only in their RESP states.
- Non-OKAY responses (SLVERR, DECERR) are passed through unchanged and do not affect state flow.

## Timing
- Reset (async assert, sync release): state=IDLE. `cmd_ready`=1. All `axi_*valid`, `bready`, `rready`, `rsp_valid` = 0. Addr/data/strb/rsp fields = 0. `axi_*prot`=PROT.
- Reset mid-transaction: outputs return to reset values immediately. The slave shares `aresetn`.
- Command accepted in cycle N: AXI valid(s) are high from N+1. With a zero-wait slave, write B completes at N+2 and `rsp_valid` rises at N+3 with `rsp_latency`=2. A read with zero wait completes identically.
- `cmd_ready` is low from N+1 until the cycle after the `rsp_valid&rsp_ready` handshake, so there is no command/response overlap.
- All outputs are registered except `cmd_ready`, which is decoded from state.

## Structure
- Package `axi_lite_pkg`: response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; master state encoding; DATA_WIDTH legality check.
- No sub-module. The latency counter and FSM stay in one module.

## Test plan
- Write 0x12345678 to 0x1000, strb 4'b1111, zero-wait slave -> `awvalid`&`wvalid` both high at N+1; `rsp_valid` at N+3, `rsp_resp`=OKAY, `rsp_latency`=2. Read of 0x1000 returns 0x12345678.
- Slave accepts W 3 cycles before AW -> `wvalid` drops after its handshake while `awvalid` is held; `awaddr` stable; single B accepted.
- Write 0xAABBCCDD with strb 4'b0101 over 0xFFFFFFFF, then read -> 0xFFBBFFDD.
- `rsp_ready` held low 5 cycles -> `rsp_valid`/fields stable; `cmd_ready` stays 0; a `cmd_valid` presented meanwhile is not accepted.
- Slave returns SLVERR on a read of an unmapped address after 4 wait cycles -> `rsp_resp`=2'b10, `rsp_latency`=5; the next command proceeds normally.
- `aresetn` asserted while `arvalid` is pending -> all valids 0 in the same cycle, `cmd_ready`=1 after release, and a fresh read succeeds.
